hazard_controller: RTL
======================

Name: hazard_controller

Overview:
- Pipeline sequencer for the 5-stage core (IF/ID/EX/MEM/WB); one instance at core top.
- Observes register indices and control bits from the decode, execute, memory and writeback stages.
- Drives three groups of controls: operand-forwarding selects into EX; stall and flush enables for the IF/ID and ID/EX registers; a global freeze for data-memory wait states.
- Owns a small FSM that tracks outstanding data-memory accesses, with a timeout.

Parameters:
- MEM_TIMEOUT, 16: max cycles in MEM_WAIT before error; legal range 2..255.
- TO_W, 8: width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- RS1_D  in  5  rs1 index of instruction in ID
- RS2_D  in  5  rs2 index of instruction in ID
- RS1_E  in  5  rs1 index in EX
- RS2_E  in  5  rs2 index in EX
- RD_E  in  5  destination index in EX
- ResultSrcE  in  1  EX instruction is a load
- PCSrcE  in  1  branch taken, resolved in EX
- RD_M  in  5  destination index in MEM
- RegWriteM  in  1  MEM instruction writes the register file
- RD_W  in  5  destination index in WB
- RegWriteW  in  1  WB instruction writes the register file
- MemReqM  in  1  MEM instruction accesses data memory
- MemReadyM  in  1  data memory completes the access this cycle
- ForwardAE  out  2  operand A select into EX
- ForwardBE  out  2  operand B select into EX
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID register
- FlushD  out  1  clear IF/ID register
- FlushE  out  1  clear ID/EX register (inject bubble)
- Freeze  out  1  hold all pipeline registers including EX/MEM and MEM/WB
- MemErr  out  1  sticky memory-timeout error

Behaviour:
- Reset (rst=0, async): FSM=RUN, wait counter=0, MemErr=0. All outputs evaluate to 0 while rst=0, independent of inputs.

Forwarding (combinational, zero latency):
- ForwardAE=10 if RegWriteM && RD_M!=0 && RD_M==RS1_E.
- Else ForwardAE=01 if RegWriteW && RD_W!=0 && RD_W==RS1_E.
- Else ForwardAE=00.
- ForwardBE uses the same rules with RS2_E.
- MEM takes priority over WB. Index x0 is never forwarded. Code 11 is never driven.

Load-use hazard (combinational):
- lu = ResultSrcE && RD_E!=0 && (RD_E==RS1_D || RD_E==RS2_D).
- When lu: StallF=StallD=1, FlushE=1. Exactly one bubble per load-use.

Branch (combinational):
- When PCSrcE: FlushD=1, FlushE=1.
- If lu and PCSrcE are both true, FlushD=FlushE=1 and StallF=StallD=0, because the flush kills the dependent instruction.

FSM, states RUN / MEM_WAIT / ERR:
- RUN: if MemReqM && !MemReadyM, go to MEM_WAIT and load counter=1. A MemReqM with MemReadyM in the same cycle means zero wait; stay in RUN.
- MEM_WAIT: Freeze=1.
  - If MemReadyM: go to RUN; Freeze drops the same cycle (combinational on MemReadyM).
  - Else if counter==MEM_TIMEOUT: go to ERR.
  - Else counter+1.
- ERR: Freeze=1, MemErr=1 (registered, sticky). Exit only via reset.
- Freeze in RUN = MemReqM && !MemReadyM, so the first wait cycle already freezes.

Freeze priority:
- While Freeze=1, StallF=StallD=1 and FlushD=FlushE=0; lu and PCSrcE are masked.
- Masked hazards re-evaluate on the first unfrozen cycle. EX contents are held, so a taken branch still flushes then.
- Forwarding selects remain live during Freeze.
- Reset asserted mid-wait returns to RUN with Freeze=0 immediately.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, add three 32-bit saturating outputs, all reset to 0:
  - PerfStall: cycles with lu && !Freeze && !PCSrcE.
  - PerfFlush: cycles with PCSrcE && !Freeze.
  - PerfWait: cycles with Freeze=1.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package (pipeline_pkg) holds:
  - Forward-select constants: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - FSM state enum: RUN, MEM_WAIT, ERR.
  - Register-index width constant: 5.
- One sub-module, forward_sel: pure combinational comparator, instanced twice (operand A, operand B).
- FSM, hazard detection and perf counters live in hazard_controller.

Test Plan:
- Forwarding:
  - RegWriteM=1, RD_M=5, RS1_E=5, RegWriteW=1, RD_W=5 -> ForwardAE=10.
  - Drop RegWriteM -> ForwardAE=01.
  - RD_M=0, RS1_E=0 -> ForwardAE=00.
- Load-use: ResultSrcE=1, RD_E=7, RS2_D=7 -> StallF=StallD=FlushE=1 for one cycle. Next cycle, with ResultSrcE=0, all clear.
- Branch with load-use: PCSrcE=1 and lu together -> FlushD=FlushE=1, StallF=StallD=0.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> Freeze=1 for exactly 3 cycles, 0 on the ready cycle, FSM back in RUN. A PCSrcE held through the wait flushes on the first unfrozen cycle.
- Timeout: MEM_TIMEOUT=4, MemReadyM held 0 -> ERR entered after 4 wait cycles; MemErr=1 and Freeze=1 persist. Asserting rst clears both asynchronously.
- Perf (macro defined): 2 load-use events, 1 branch, 3 wait cycles -> PerfStall=2, PerfFlush=1, PerfWait=3.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 5-stage core's pipeline control.
// Forward-select codes, memory-wait FSM states and the register-index width.
package pipeline_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } mem_state_e;

  // Saturating increment for the 32-bit event counters.
  function automatic logic [31:0] satInc(input logic [31:0] value);
    return (value == '1) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/forward_sel.sv
// Operand-forwarding comparator for one EX source operand.
// The MEM-stage producer wins over WB; register x0 is never forwarded.
module forward_sel
  import pipeline_pkg::*;
(
  input  logic [REG_W-1:0] rsE,
  input  logic [REG_W-1:0] rdM,
  input  logic             regWriteM,
  input  logic [REG_W-1:0] rdW,
  input  logic             regWriteW,
  output logic [1:0]       forwardSel
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    forwardSel = FWD_RF;
    if (regWriteM && (rdM != '0) && (rdM == rsE)) begin
      forwardSel = FWD_MEM;
    end else if (regWriteW && (rdW != '0) && (rdW == rsE)) begin
      forwardSel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer: EX forwarding, load-use/branch stall+flush, and memory-wait freeze with timeout.
// Optional build macro HAZARD_PERF_CNT_EN adds PerfStall/PerfFlush/PerfWait saturating counters.
module hazard_controller
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] RS1_D,
  input  logic [REG_W-1:0] RS2_D,
  input  logic [REG_W-1:0] RS1_E,
  input  logic [REG_W-1:0] RS2_E,
  input  logic [REG_W-1:0] RD_E,
  input  logic             ResultSrcE,
  input  logic             PCSrcE,
  input  logic [REG_W-1:0] RD_M,
  input  logic             RegWriteM,
  input  logic [REG_W-1:0] RD_W,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             Freeze,
  output logic             MemErr
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      PerfStall,
  output logic [31:0]      PerfFlush,
  output logic [31:0]      PerfWait
`endif
);

  localparam logic [TO_W-1:0] TIMEOUT_V = TO_W'(MEM_TIMEOUT);

  mem_state_e      state, stateNext;
  logic [TO_W-1:0] waitCnt, waitCntNext;
  logic            memErrQ;
  logic            freezeRaw;
  logic            loadUse;
  logic [1:0]      fwdA, fwdB;

  // ---------------- Forwarding ----------------
  forward_sel uFwdA (
    .rsE       (RS1_E),
    .rdM       (RD_M),
    .regWriteM (RegWriteM),
    .rdW       (RD_W),
    .regWriteW (RegWriteW),
    .forwardSel(fwdA)
  );

  forward_sel uFwdB (
    .rsE       (RS2_E),
    .rdM       (RD_M),
    .regWriteM (RegWriteM),
    .rdW       (RD_W),
    .regWriteW (RegWriteW),
    .forwardSel(fwdB)
  );

  // Every output reads as zero while reset is held, regardless of the stage inputs.
  assign ForwardAE = rst ? fwdA : FWD_RF;
  assign ForwardBE = rst ? fwdB : FWD_RF;

  // ---------------- Memory-wait FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments and an asynchronous active-low reset.
    if (!rst) begin
      state   <= RUN;
      waitCnt <= '0;
      memErrQ <= 1'b0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      memErrQ <= memErrQ | (stateNext == ERR);
    end
  end

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    freezeRaw   = 1'b0;
    unique case (state)
      RUN: begin
        // A request completing in the same cycle is a zero-wait access.
        if (MemReqM && !MemReadyM) begin
          stateNext   = MEM_WAIT;
          waitCntNext = TO_W'(1);
          freezeRaw   = 1'b1;
        end
      end
      MEM_WAIT: begin
        freezeRaw = !MemReadyM;
        if (MemReadyM) begin
          stateNext   = RUN;
          waitCntNext = '0;
        end else if (waitCnt == TIMEOUT_V) begin
          stateNext = ERR;
        end else begin
          waitCntNext = waitCnt + 1'b1;
        end
      end
      ERR: begin
        freezeRaw = 1'b1;
      end
      default: begin
        stateNext   = RUN;
        waitCntNext = '0;
      end
    endcase
  end

  assign Freeze = rst & freezeRaw;
  assign MemErr = memErrQ;

  // ---------------- Stall / flush ----------------
  assign loadUse = ResultSrcE && (RD_E != '0) && ((RD_E == RS1_D) || (RD_E == RS2_D));

  // Freeze masks hazards; a taken branch kills the dependent instruction, so it beats load-use.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (rst) begin
      if (freezeRaw) begin
        StallF = 1'b1;
        StallD = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (loadUse) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // ---------------- Performance counters ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PerfStall <= '0;
      PerfFlush <= '0;
      PerfWait  <= '0;
    end else begin
      if (loadUse && !freezeRaw && !PCSrcE) PerfStall <= satInc(PerfStall);
      if (PCSrcE && !freezeRaw)             PerfFlush <= satInc(PerfFlush);
      if (freezeRaw)                        PerfWait  <= satInc(PerfWait);
    end
  end
`endif

endmodule
